// File: rtl/rv32i_decode.sv
// Registered RV32I instruction decoder: splits the fetched word into raw fields,
// builds the format-specific immediate and flags illegal or unsupported encodings.
module rv32i_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] insn,
    output logic [4:0]  opcode,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic        invalid,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_MISC   = 5'b00011;
    localparam logic [4:0] OP_ALUIMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALU    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [4:0]  op_d;
    logic [2:0]  f3_d;
    logic [6:0]  f7_d;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_d;
    logic        bad_d;

    assign op_d = insn[6:2];
    assign f3_d = insn[14:12];
    assign f7_d = insn[31:25];

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    always_comb begin
        imm_d = 32'h0;
        bad_d = 1'b0;

        if (insn == 32'h0 || insn[1:0] != 2'b11)
            bad_d = 1'b1;

        case (op_d)
            OP_LOAD: begin
                imm_d = imm_i;
                if (f3_d == 3'b011 || f3_d == 3'b110 || f3_d == 3'b111)
                    bad_d = 1'b1;
            end
            OP_MISC: begin
                imm_d = imm_i;
            end
            OP_ALUIMM: begin
                imm_d = imm_i;
                // shift-immediates carry funct7 in the upper immediate bits
                if (f3_d == 3'b001 && f7_d != F7_BASE)
                    bad_d = 1'b1;
                if (f3_d == 3'b101 && f7_d != F7_BASE && f7_d != F7_ALT)
                    bad_d = 1'b1;
            end
            OP_AUIPC, OP_LUI: begin
                imm_d = imm_u;
            end
            OP_STORE: begin
                imm_d = imm_s;
                if (f3_d >= 3'b011)
                    bad_d = 1'b1;
            end
            OP_ALU: begin
                if (f7_d != F7_BASE && f7_d != F7_ALT)
                    bad_d = 1'b1;
                if (f7_d == F7_ALT && f3_d != 3'b000 && f3_d != 3'b101)
                    bad_d = 1'b1;
            end
            OP_BRANCH: begin
                imm_d = imm_b;
                if (f3_d == 3'b010 || f3_d == 3'b011)
                    bad_d = 1'b1;
            end
            OP_JALR: begin
                imm_d = imm_i;
                if (f3_d != 3'b000)
                    bad_d = 1'b1;
            end
            OP_JAL: begin
                imm_d = imm_j;
            end
            OP_SYSTEM: begin
                // privileged-op legality for funct3=000 is left to later stages
                imm_d = imm_i;
                if (f3_d == 3'b100)
                    bad_d = 1'b1;
            end
            default: begin
                bad_d = 1'b1;
            end
        endcase

        if (bad_d)
            imm_d = 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode  <= 5'h0;
            funct7  <= 7'h0;
            funct3  <= 3'h0;
            invalid <= 1'b0;
            rd      <= 5'h0;
            rs1     <= 5'h0;
            rs2     <= 5'h0;
            imm     <= 32'h0;
        end else if (en) begin
            opcode  <= op_d;
            funct7  <= f7_d;
            funct3  <= f3_d;
            invalid <= bad_d;
            rd      <= insn[11:7];
            rs1     <= insn[19:15];
            rs2     <= insn[24:20];
            imm     <= imm_d;
        end
    end

endmodule

// File: tb/tb_rv32i_decode.sv
// Directed bench for rv32i_decode: hand-computed opcode/imm/invalid per vector,
// plus reset, hold and asynchronous-reset behaviour.
module tb_rv32i_decode;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] insn;
    logic [4:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    int checks   = 0;
    int failures = 0;

    rv32i_decode dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .insn    (insn),
        .opcode  (opcode),
        .funct7  (funct7),
        .funct3  (funct3),
        .invalid (invalid),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".opcode"}, 32'(opcode), 32'h0);
        check({tag, ".funct7"}, 32'(funct7), 32'h0);
        check({tag, ".funct3"}, 32'(funct3), 32'h0);
        check({tag, ".rd"}, 32'(rd), 32'h0);
        check({tag, ".rs1"}, 32'(rs1), 32'h0);
        check({tag, ".rs2"}, 32'(rs2), 32'h0);
        check({tag, ".imm"}, imm, 32'h0);
        check({tag, ".invalid"}, 32'(invalid), 32'h0);
    endtask

    // Drive one word with en=1 on a falling edge, sample on the following falling edge.
    task automatic run_vec(input string tag, input logic [31:0] w, input logic [4:0] exp_op,
                           input logic [31:0] exp_imm, input logic exp_inv);
        @(negedge clk);
        insn = w;
        en   = 1'b1;
        @(negedge clk);
        check({tag, ".opcode"}, 32'(opcode), 32'(exp_op));
        check({tag, ".rd"}, 32'(rd), 32'(w[11:7]));
        check({tag, ".rs1"}, 32'(rs1), 32'(w[19:15]));
        check({tag, ".rs2"}, 32'(rs2), 32'(w[24:20]));
        check({tag, ".funct3"}, 32'(funct3), 32'(w[14:12]));
        check({tag, ".funct7"}, 32'(funct7), 32'(w[31:25]));
        check({tag, ".imm"}, imm, exp_imm);
        check({tag, ".invalid"}, 32'(invalid), 32'(exp_inv));
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        insn = 32'h0000_0013;

        repeat (2) @(negedge clk);
        check_all_zero("reset");

        rst = 1'b1;
        @(negedge clk);
        check("rel.opcode", 32'(opcode), 32'h04);
        check("rel.rd", 32'(rd), 32'h0);
        check("rel.rs1", 32'(rs1), 32'h0);
        check("rel.imm", imm, 32'h0);
        check("rel.invalid", 32'(invalid), 32'h0);

        run_vec("addi",   32'hFFF1_0093, 5'b00100, 32'hFFFF_FFFF, 1'b0);
        check("addi.rd_lit", 32'(rd), 32'd1);
        check("addi.rs1_lit", 32'(rs1), 32'd2);
        run_vec("sw",     32'h0051_2423, 5'b01000, 32'h0000_0008, 1'b0);
        check("sw.rs2_lit", 32'(rs2), 32'd5);
        check("sw.f3_lit", 32'(funct3), 32'd2);
        run_vec("beq",    32'hFE20_8EE3, 5'b11000, 32'hFFFF_FFFC, 1'b0);
        run_vec("lui",    32'h1234_51B7, 5'b01101, 32'h1234_5000, 1'b0);
        check("lui.rd_lit", 32'(rd), 32'd3);
        run_vec("jal",    32'h0010_00EF, 5'b11011, 32'h0000_0800, 1'b0);
        run_vec("auipc",  32'hFFFF_F117, 5'b00101, 32'hFFFF_F000, 1'b0);
        run_vec("add",    32'h0020_81B3, 5'b01100, 32'h0000_0000, 1'b0);
        run_vec("sub",    32'h4020_81B3, 5'b01100, 32'h0000_0000, 1'b0);
        run_vec("srai",   32'h4031_5093, 5'b00100, 32'h0000_0403, 1'b0);
        run_vec("jalr",   32'h8000_80E7, 5'b11001, 32'hFFFF_F800, 1'b0);
        run_vec("ecall",  32'h0000_0073, 5'b11100, 32'h0000_0000, 1'b0);
        run_vec("fence",  32'h0FF0_000F, 5'b00011, 32'h0000_00FF, 1'b0);
        run_vec("lbu",    32'hFFC1_4083, 5'b00000, 32'hFFFF_FFFC, 1'b0);

        run_vec("zero",   32'h0000_0000, 5'b00000, 32'h0, 1'b1);
        run_vec("lo00",   32'h0000_000C, 5'b00011, 32'h0, 1'b1);
        run_vec("subf3",  32'h4000_1033, 5'b01100, 32'h0, 1'b1);
        run_vec("ld",     32'h0000_3003, 5'b00000, 32'h0, 1'b1);
        run_vec("badop",  32'hFFF0_007F, 5'b11111, 32'h0, 1'b1);
        run_vec("slli7",  32'h4031_1093, 5'b00100, 32'h0, 1'b1);
        run_vec("sd",     32'h0051_3423, 5'b01000, 32'h0, 1'b1);
        run_vec("brf3",   32'hFE20_AEE3, 5'b11000, 32'h0, 1'b1);
        run_vec("jalrf3", 32'h0000_10E7, 5'b11001, 32'h0, 1'b1);
        run_vec("aluf7",  32'h0200_81B3, 5'b01100, 32'h0, 1'b1);
        run_vec("sys100", 32'h0000_4073, 5'b11100, 32'h0, 1'b1);

        run_vec("hold0",  32'hFFF1_0093, 5'b00100, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        insn = 32'h1234_51B7;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.imm", imm, 32'hFFFF_FFFF);
            check("hold.rd", 32'(rd), 32'd1);
            check("hold.opcode", 32'(opcode), 32'h04);
        end
        en = 1'b1;
        @(negedge clk);
        check("hold.reload_imm", imm, 32'h1234_5000);
        check("hold.reload_rd", 32'(rd), 32'd3);

        // asynchronous clear between edges, then reset dominating en=1
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async");
        insn = 32'hFFF1_0093;
        en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst_wins");
        rst = 1'b1;
        @(negedge clk);
        check("post.imm", imm, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
